// File: rtl/word128_buffer_pkg.sv
// word128_buffer_pkg: shared word width, default depth and level-width helper for the 128-bit buffer.
package word128_pkg;
  localparam int WORD_W = 128;
  localparam int DEPTH_DEF = 4;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/word128_buffer_if.sv
// word128_buffer_if: producer/consumer signals of the 128-bit buffer.
// drop_cnt exists only when WORD128_BUFFER_STATS_EN is defined.
interface word128_buffer_if import word128_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
);
  logic [WORD_W-1:0] in_data;
  logic in_valid;
  logic [WORD_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [lvl_w(DEPTH)-1:0] level;
  logic ovf;
  logic ovf_clr;
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
`ifdef WORD128_BUFFER_STATS_EN
  logic [CNT_W-1:0] drop_cnt;
  modport slave (input in_data, in_valid, out_ready, ovf_clr,
                 output out_data, out_valid, level, ovf, drop_cnt);
  modport master (output in_data, in_valid, out_ready, ovf_clr,
                  input out_data, out_valid, level, ovf, drop_cnt);
`else
  modport slave (input in_data, in_valid, out_ready, ovf_clr,
                 output out_data, out_valid, level, ovf);
  modport master (output in_data, in_valid, out_ready, ovf_clr,
                  input out_data, out_valid, level, ovf);
`endif
endinterface

// File: rtl/word128_buffer_ram.sv
// word128_ram: DEPTH x 128 register array, one write port, one registered read port.
module word128_ram import word128_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  // write-first bypass lets a word pushed into an empty queue reach the head next cycle
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= (i_we && i_waddr == i_raddr) ? i_wdata : r_mem[i_raddr];
  end
endmodule

// File: rtl/word128_buffer.sv
// word128_buffer: in-order queue of 128-bit words with registered head, drop-on-full and sticky overflow.
// Define WORD128_BUFFER_STATS_EN to add the saturating drop_cnt counter.
module word128_buffer import word128_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  word128_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
    $error("DEPTH must be a power of two in 2..16 and CNT_W at least 1");
  end
  logic [AW-1:0] r_wptr, r_rptr, w_raddr;
  logic [LW-1:0] r_level;
  logic r_ovf, w_pop, w_free, w_push, w_drop;
  assign w_pop = (r_level != '0) && bus.out_ready;
  assign w_free = (r_level < LW'(DEPTH)) || w_pop;
  assign w_push = bus.in_valid && w_free && !rst;
  assign w_drop = bus.in_valid && !w_free && !rst;
  // read the next head so the registered read port already holds it after a pop
  assign w_raddr = w_pop ? r_rptr + AW'(1) : r_rptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      r_ovf <= w_drop || (r_ovf && !bus.ovf_clr);
    end
  end
  assign bus.out_valid = r_level != '0;
  assign bus.level = r_level;
  assign bus.ovf = r_ovf;
  word128_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .i_we(w_push),
    .i_waddr(r_wptr),
    .i_wdata(bus.in_data),
    .i_raddr(w_raddr),
    .o_rdata(bus.out_data)
  );
`ifdef WORD128_BUFFER_STATS_EN
  logic [CNT_W-1:0] r_drop_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= (&r_drop_cnt) ? r_drop_cnt : r_drop_cnt + CNT_W'(1);
    else if (bus.ovf_clr) r_drop_cnt <= '0;
  end
  assign bus.drop_cnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_word128_buffer.sv
// tb_word128_buffer: directed scenarios plus random traffic against a queue-based scoreboard model.
module tb_word128_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  word128_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  word128_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic [127:0] exp_q[$];
  bit m_ovf = 1'b0;
  bit m_pop, m_acc;
  logic [CNT_W-1:0] m_cnt = '0;
  localparam logic [127:0] W1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  task automatic step(input logic v, input logic [127:0] d, input logic rdy, input logic clr, input logic r);
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = rdy;
    bus.ovf_clr = clr;
    rst = r;
    @(posedge clk);
    #1;
  endtask
  // Monitor compares the DUT with the model, then advances the model with the inputs about to be clocked.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_valid", bus.out_valid, exp_q.size() != 0);
      chk("mon_level", bus.level, exp_q.size());
      chk("mon_ovf", bus.ovf, m_ovf);
`ifdef WORD128_BUFFER_STATS_EN
      chk("mon_cnt", bus.drop_cnt, m_cnt);
`endif
      if (exp_q.size() != 0) chk("mon_data", bus.out_data, exp_q[0]);
    end
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
    end else begin
      m_pop = exp_q.size() != 0 && bus.out_ready;
      m_acc = bus.in_valid && (exp_q.size() < DEPTH || m_pop);
      if (m_pop) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back(bus.in_data);
      if (bus.in_valid && !m_acc) begin
        m_ovf = 1'b1;
        if (m_cnt != '1) m_cnt++;
      end else if (bus.ovf_clr) begin
        m_ovf = 1'b0;
        m_cnt = '0;
      end
    end
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    mon_en = 1'b1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_ovf", bus.ovf, 0);
    step(1, W1, 1, 0, 0);
    chk("single_valid", bus.out_valid, 1);
    chk("single_data", bus.out_data, W1);
    chk("single_level1", bus.level, 1);
    step(0, 0, 1, 0, 0);
    chk("single_level0", bus.level, 0);
    chk("single_gone", bus.out_valid, 0);
    for (int i = 1; i <= 6; i++) step(1, i, 0, 0, 0);
    chk("fill_level", bus.level, 4);
    chk("fill_ovf", bus.ovf, 1);
`ifdef WORD128_BUFFER_STATS_EN
    chk("fill_cnt", bus.drop_cnt, 2);
`endif
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", bus.out_data, i);
      step(0, 0, 1, 0, 0);
    end
    chk("drain_level", bus.level, 0);
    step(0, 0, 0, 1, 0);
    chk("clr_ovf", bus.ovf, 0);
    for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 0);
    step(1, 5, 1, 0, 0);
    chk("fullsim_level", bus.level, 4);
    chk("fullsim_ovf", bus.ovf, 0);
    chk("fullsim_head", bus.out_data, 2);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("hold_data", bus.out_data, 2);
    end
    step(1, 9, 0, 1, 0);
    chk("race_ovf", bus.ovf, 1);
`ifdef WORD128_BUFFER_STATS_EN
    chk("race_cnt", bus.drop_cnt, 1);
`endif
    step(0, 0, 0, 1, 0);
    chk("race_clr_ovf", bus.ovf, 0);
`ifdef WORD128_BUFFER_STATS_EN
    chk("race_clr_cnt", bus.drop_cnt, 0);
`endif
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) step(1, i, 0, 0, 0);
    chk("mid_level3", bus.level, 3);
    step(1, 7, 0, 0, 1);
    chk("mid_level0", bus.level, 0);
    chk("mid_valid0", bus.out_valid, 0);
    step(0, 0, 1, 0, 0);
    chk("mid_nostore", bus.out_valid, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3) != 0, {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom_range(2) != 0, $urandom_range(15) == 0, $urandom_range(299) == 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/word128_buffer.md
WORD128_BUFFER -- requirements
Module: word128_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 128-bit entries; power of two, 2..16.
REQ-002 SHALL have parameter CNT_W, default 16, width of the drop counter (used only with WORD128_BUFFER_STATS_EN).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  128  word from the 24-to-128 gearbox.
REQ-006 SHALL have port in_valid  input  1  in_data valid this cycle; no backpressure upstream.
REQ-007 SHALL have port out_data  output  128  head-of-queue word.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port ovf  output  1  sticky overflow flag.
REQ-012 SHALL have port ovf_clr  input  1  clears ovf.
REQ-013 SHALL have port drop_cnt  output  CNT_W  dropped-word count; present only with WORD128_BUFFER_STATS_EN.

Function
REQ-014 SHALL store words in arrival order: push when in_valid and a slot is free; pop when out_valid and out_ready.
REQ-015 SHALL use registered output, no fall-through: word pushed into empty queue in cycle N appears on out_valid/out_data in cycle N+1.
REQ-016 SHALL treat a slot as free if level < DEPTH, or level == DEPTH and a pop occurs in the same cycle.
REQ-017 SHALL drop in_data when in_valid and no slot is free; queue contents and pointers unchanged.
REQ-018 SHALL set ovf in the cycle after a drop; ovf stays high until ovf_clr or rst.
REQ-019 SHALL give priority to setting: drop and ovf_clr in the same cycle leaves ovf high.
REQ-020 SHALL update level by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-021 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; full/empty are derived from level, not pointer equality.
REQ-023 SHALL ignore out_ready when out_valid is low, so the queue never underflows.

Reset
REQ-024 SHALL drive out_valid=0, level=0, ovf=0 and pointers=0 in the cycle after rst is sampled high, and drop_cnt=0 when present.
REQ-025 SHALL discard all stored words when rst is asserted mid-operation; in_valid is ignored while rst is high.
REQ-026 SHALL leave storage contents unreset; out_data is don't-care while out_valid=0.

Configuration
REQ-027 SHALL, with WORD128_BUFFER_STATS_EN defined, provide drop_cnt: +1 per dropped word, saturating at all-ones, cleared by rst or ovf_clr, with increment winning over a simultaneous ovf_clr.
REQ-028 SHALL, without WORD128_BUFFER_STATS_EN, omit the drop_cnt port and its logic; all other behaviour is identical.

Structure
REQ-029 SHALL place WORD_W=128, the default DEPTH and the level width function in package word128_pkg.
REQ-030 SHALL implement storage in sub-module word128_ram: DEPTH x 128 register array with 1 write port and 1 registered read port. Pointer/level/flag control stays in word128_buffer.

Verification
REQ-031 Single word: rst, then in_valid=1 for 1 cycle with 0x0123...EF, out_ready=1 -> out_valid high exactly 1 cycle later with the same data; level 1 then 0.
REQ-032 Fill/overflow: DEPTH=4, out_ready=0, 6 consecutive pushes of 1..6 -> level=4, ovf=1, drop_cnt=2 (STATS_EN); then drain reads 1,2,3,4 in order.
REQ-033 Full simultaneous: level=4, in_valid and out_ready both high for 1 cycle -> no drop, ovf=0, level stays 4, next head is word 2.
REQ-034 Backpressure hold: out_ready low for 5 cycles with out_valid high -> out_data unchanged every cycle.
REQ-035 Clear race: drop and ovf_clr in the same cycle -> ovf=1 and drop_cnt=1; ovf_clr alone on the next cycle -> ovf=0 and drop_cnt=0.
REQ-036 Mid-operation reset: level=3, rst for 1 cycle with in_valid=1 -> level=0, out_valid=0, no word is stored.
